// File: rtl/mem_initiator_pkg.sv
// Shared types and defaults for the mem_initiator register-file bus initiator.
// Default address, data and length widths plus the read-latency ceiling.
package mem_initiator_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 4;
    localparam int RD_LAT_MAX = 7;
    localparam int LAT_W      = 3;

    typedef enum logic [1:0] {
        IDLE,
        WR_BEAT,
        RD_ISSUE,
        RD_RESP
    } state_t;

endpackage

// File: rtl/mem_initiator_if.sv
// Command, write-beat and read-response handshakes of mem_initiator.
// master = command producer, slave = mem_initiator.
interface mem_initiator_if
    import mem_initiator_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data,
        output rd_ready,
        input  cmd_ready, wr_ready,
        input  rd_valid, rd_data, rd_last
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data,
        input  rd_ready,
        output cmd_ready, wr_ready,
        output rd_valid, rd_data, rd_last
    );

endinterface

// File: rtl/mem_initiator.sv
// Bus initiator sequencing the 8-bit register-file memory pins.
// MEM_INITIATOR_BURST_EN enables multi-beat bursts with address auto-increment.
module mem_initiator
    import mem_initiator_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_initiator_if.slave    bus,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_read_write,
    output logic              mem_chip_en,
    input  logic [DATA_W-1:0] mem_data_out
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] mdin_q, mdin_d;
    logic              ce_q, ce_d;
    logic              rw_q, rw_d;
    logic              last;

`ifdef MEM_INITIATOR_BURST_EN
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              rd_last_q, rd_last_d;

    assign last = (cnt_q == '0);
`else
    logic              unused_len;

    assign unused_len = ^bus.cmd_len;
    assign last       = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        lat_d       = lat_q;
        rd_data_d   = rd_data_q;
        maddr_d     = maddr_q;
        mdin_d      = mdin_q;
        rw_d        = rw_q;
        ce_d        = 1'b0;
`ifdef MEM_INITIATOR_BURST_EN
        cnt_d       = cnt_q;
        rd_last_d   = rd_last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    addr_d = bus.cmd_addr;
`ifdef MEM_INITIATOR_BURST_EN
                    cnt_d  = bus.cmd_len;
`endif
                    if (bus.cmd_write) begin
                        state_d = WR_BEAT;
                    end else begin
                        state_d = RD_ISSUE;
                        ce_d    = 1'b1;
                        rw_d    = 1'b0;
                        maddr_d = bus.cmd_addr;
                        lat_d   = '0;
                    end
                end
            end
            WR_BEAT: begin
                if (bus.wr_valid) begin
                    ce_d    = 1'b1;
                    rw_d    = 1'b1;
                    maddr_d = addr_q;
                    mdin_d  = bus.wr_data;
`ifdef MEM_INITIATOR_BURST_EN
                    addr_d  = addr_q + ADDR_W'(1);
                    cnt_d   = cnt_q - LEN_W'(1);
`endif
                    if (last) state_d = IDLE;
                end
            end
            RD_ISSUE: begin
                // Strobe drops on the edge that samples the memory output.
                if (lat_q == LAT_W'(RD_LAT - 1)) begin
                    rd_data_d = mem_data_out;
`ifdef MEM_INITIATOR_BURST_EN
                    rd_last_d = last;
`endif
                    state_d   = RD_RESP;
                end else begin
                    ce_d  = 1'b1;
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            RD_RESP: begin
                if (bus.rd_ready) begin
                    if (last) begin
                        state_d = IDLE;
                    end else begin
`ifdef MEM_INITIATOR_BURST_EN
                        addr_d  = addr_q + ADDR_W'(1);
                        cnt_d   = cnt_q - LEN_W'(1);
`endif
                        state_d = RD_ISSUE;
                        ce_d    = 1'b1;
                        rw_d    = 1'b0;
                        maddr_d = addr_d;
                        lat_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            lat_q       <= '0;
            rd_data_q   <= '0;
            cmd_ready_q <= 1'b0;
            maddr_q     <= '0;
            mdin_q      <= '0;
            ce_q        <= 1'b0;
            rw_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            lat_q       <= lat_d;
            rd_data_q   <= rd_data_d;
            cmd_ready_q <= cmd_ready_d;
            maddr_q     <= maddr_d;
            mdin_q      <= mdin_d;
            ce_q        <= ce_d;
            rw_q        <= rw_d;
        end
    end

`ifdef MEM_INITIATOR_BURST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            rd_last_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rd_last_q <= rd_last_d;
        end
    end

    assign bus.rd_last = rd_last_q;
`else
    assign bus.rd_last = 1'b1;
`endif

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.wr_ready   = (state_q == WR_BEAT);
    assign bus.rd_valid   = (state_q == RD_RESP);
    assign bus.rd_data    = rd_data_q;
    assign busy           = (state_q != IDLE);
    assign mem_address    = maddr_q;
    assign mem_data_in    = mdin_q;
    assign mem_read_write = rw_q;
    assign mem_chip_en    = ce_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed self-checking bench for mem_initiator with a register-file model.
// Burst steps run only when MEM_INITIATOR_BURST_EN is defined.
module tb_mem_initiator;
    import mem_initiator_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic       ce;
    logic       rw;
    logic [7:0] maddr;
    logic [7:0] mdin;
    logic [7:0] mdout;
    logic [7:0] mem [256];
    int         checks = 0;
    int         failures = 0;
    int         wr_pulses = 0;

    mem_initiator_if bus ();

    mem_initiator dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .busy           (busy),
        .mem_address    (maddr),
        .mem_data_in    (mdin),
        .mem_read_write (rw),
        .mem_chip_en    (ce),
        .mem_data_out   (mdout)
    );

    always #5 clk = ~clk;

    assign mdout = mem[maddr];

    always @(posedge clk) begin
        if (ce && rw) begin
            mem[maddr] <= mdin;
            wr_pulses  <= wr_pulses + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cmd(input logic w, input logic [7:0] a,
                       input logic [3:0] l);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
    endtask

`ifdef MEM_INITIATOR_BURST_EN
    logic [7:0] exp_a [4];
`endif

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_ready  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ce", ce, 0);
        chk("rst_rw", rw, 0);
        chk("rst_addr", maddr, 0);
        chk("rst_din", mdin, 0);
`ifdef MEM_INITIATOR_BURST_EN
        chk("rst_rd_last", bus.rd_last, 0);
`else
        chk("rst_rd_last_tied", bus.rd_last, 1);
`endif
        rst_n = 1'b1;
        chk("cmd_ready_pre_edge", bus.cmd_ready, 0);
        tick();
        chk("cmd_ready_post_edge", bus.cmd_ready, 1);
        chk("idle_ce", ce, 0);

        // single write 0x10 <- 0xA5
        cmd(1'b1, 8'h10, 4'h0);
        tick();
        bus.cmd_valid = 1'b0;
        chk("wr_ready", bus.wr_ready, 1);
        chk("wr_cmd_ready_low", bus.cmd_ready, 0);
        chk("wr_busy", busy, 1);
        chk("wr_ce_pre", ce, 0);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hA5;
        tick();
        bus.wr_valid = 1'b0;
        chk("wr_ce", ce, 1);
        chk("wr_rw", rw, 1);
        chk("wr_addr", maddr, 8'h10);
        chk("wr_din", mdin, 8'hA5);
        chk("wr_done_ready", bus.cmd_ready, 1);
        tick();
        chk("wr_ce_off", ce, 0);
        chk("wr_din_hold", mdin, 8'hA5);
        chk("wr_pulses_1", wr_pulses, 1);

        // single read 0x10 with backpressure
        cmd(1'b0, 8'h10, 4'h0);
        tick();
        bus.cmd_valid = 1'b0;
        chk("rd_ce", ce, 1);
        chk("rd_rw", rw, 0);
        chk("rd_addr", maddr, 8'h10);
        chk("rd_valid_early", bus.rd_valid, 0);
        tick();
        chk("rd_valid", bus.rd_valid, 1);
        chk("rd_data", bus.rd_data, 8'hA5);
        chk("rd_last", bus.rd_last, 1);
        chk("rd_ce_off", ce, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", bus.rd_valid, 1);
            chk("bp_data", bus.rd_data, 8'hA5);
            chk("bp_ce", ce, 0);
        end
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        chk("rd_done_valid", bus.rd_valid, 0);
        chk("rd_done_ready", bus.cmd_ready, 1);
        chk("rd_done_busy", busy, 0);
        chk("rd_done_ce", ce, 0);

        // write stall with a read command held off behind it
        cmd(1'b1, 8'h20, 4'h0);
        tick();
        cmd(1'b0, 8'h20, 4'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_ce", ce, 0);
            chk("stall_cmd_ready", bus.cmd_ready, 0);
            chk("stall_wr_ready", bus.wr_ready, 1);
        end
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h5A;
        tick();
        bus.wr_valid = 1'b0;
        chk("stall_wr_ce", ce, 1);
        chk("stall_wr_addr", maddr, 8'h20);
        chk("stall_wr_din", mdin, 8'h5A);
        chk("stall_idle", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("held_rd_ce", ce, 1);
        chk("held_rd_rw", rw, 0);
        chk("held_rd_addr", maddr, 8'h20);
        bus.rd_ready = 1'b1;
        tick();
        chk("held_rd_valid", bus.rd_valid, 1);
        chk("held_rd_data", bus.rd_data, 8'h5A);
        tick();
        bus.rd_ready = 1'b0;
        chk("held_rd_done", busy, 0);
        chk("wr_pulses_2", wr_pulses, 2);

`ifdef MEM_INITIATOR_BURST_EN
        // wrapping 4-beat write with a 4-cycle gap
        cmd(1'b1, 8'hFE, 4'h3);
        tick();
        bus.cmd_valid = 1'b0;
        bus.wr_valid  = 1'b1;
        bus.wr_data   = 8'h01;
        tick();
        chk("bw0_addr", maddr, 8'hFE);
        chk("bw0_din", mdin, 8'h01);
        chk("bw0_ce", ce, 1);
        bus.wr_data = 8'h02;
        tick();
        chk("bw1_addr", maddr, 8'hFF);
        chk("bw1_din", mdin, 8'h02);
        bus.wr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bw_gap_ce", ce, 0);
        end
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h03;
        tick();
        chk("bw2_addr", maddr, 8'h00);
        chk("bw2_din", mdin, 8'h03);
        bus.wr_data = 8'h04;
        tick();
        bus.wr_valid = 1'b0;
        chk("bw3_addr", maddr, 8'h01);
        chk("bw3_din", mdin, 8'h04);
        chk("bw_done_wr_ready", bus.wr_ready, 0);
        chk("bw_done_cmd_ready", bus.cmd_ready, 1);
        tick();
        chk("wr_pulses_6", wr_pulses, 6);

        // wrapping 4-beat read-back, rd_ready held high
        exp_a[0] = 8'hFE;
        exp_a[1] = 8'hFF;
        exp_a[2] = 8'h00;
        exp_a[3] = 8'h01;
        cmd(1'b0, 8'hFE, 4'h3);
        bus.rd_ready = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("br_ce", ce, 1);
            chk("br_addr", maddr, 32'(exp_a[i]));
            tick();
            chk("br_valid", bus.rd_valid, 1);
            chk("br_data", bus.rd_data, 32'(i + 1));
            chk("br_last", bus.rd_last, 32'(i == 3));
            tick();
        end
        bus.rd_ready = 1'b0;
        chk("br_done_busy", busy, 0);
        chk("br_done_valid", bus.rd_valid, 0);

        // 2-beat read with 5 cycles of backpressure on beat 1
        cmd(1'b0, 8'hFE, 4'h1);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        chk("bbp_data0", bus.rd_data, 8'h01);
        chk("bbp_last0", bus.rd_last, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bbp_valid", bus.rd_valid, 1);
            chk("bbp_hold", bus.rd_data, 8'h01);
            chk("bbp_ce", ce, 0);
            chk("bbp_addr", maddr, 8'hFE);
        end
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        chk("bbp_ce1", ce, 1);
        chk("bbp_addr1", maddr, 8'hFF);
        chk("bbp_valid_low", bus.rd_valid, 0);
        tick();
        chk("bbp_data1", bus.rd_data, 8'h02);
        chk("bbp_last1", bus.rd_last, 1);
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        chk("bbp_done", busy, 0);

        // reset during RD_ISSUE of beat 2
        cmd(1'b0, 8'hFE, 4'h3);
        bus.rd_ready = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        chk("mr_ce_beat2", ce, 1);
        chk("mr_addr_beat2", maddr, 8'hFF);
`else
        // cmd_len ignored: one beat only
        cmd(1'b0, 8'h10, 4'hF);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        chk("nl_valid", bus.rd_valid, 1);
        chk("nl_data", bus.rd_data, 8'hA5);
        chk("nl_last", bus.rd_last, 1);
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        chk("nl_idle", busy, 0);
        chk("nl_cmd_ready", bus.cmd_ready, 1);
        chk("nl_no_strobe", ce, 0);

        // reset during RD_ISSUE
        cmd(1'b0, 8'h20, 4'h0);
        tick();
        bus.cmd_valid = 1'b0;
        chk("mr_ce_issue", ce, 1);
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("mr_ce_async", ce, 0);
        chk("mr_busy", busy, 0);
        chk("mr_rd_valid", bus.rd_valid, 0);
        chk("mr_cmd_ready", bus.cmd_ready, 0);
        @(negedge clk);
        bus.rd_ready = 1'b0;
        rst_n = 1'b1;
        chk("mr_cmd_ready_pre", bus.cmd_ready, 0);
        tick();
        chk("mr_cmd_ready_post", bus.cmd_ready, 1);
        chk("mr_no_valid", bus.rd_valid, 0);

        // next command after reset runs normally
        cmd(1'b0, 8'h10, 4'h0);
        bus.rd_ready = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        chk("post_ce", ce, 1);
        chk("post_addr", maddr, 8'h10);
        tick();
        chk("post_valid", bus.rd_valid, 1);
        chk("post_data", bus.rd_data, 8'hA5);
        chk("post_last", bus.rd_last, 1);
        tick();
        bus.rd_ready = 1'b0;
        chk("post_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
